// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// the default reset fetch address and the bubble instruction word.
package fetch_pkg;

   // Fetch FSM states; encoding kept explicit so it matches older netlists.
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,   // request outstanding, data may be delivered this cycle
      S_HOLD = 2'd1,   // one fetched word parked in the hold buffer
      S_DROP = 2'd2    // wrong-path request in flight, its data is discarded
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

   // Force a byte address onto a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Owns the fetch PC, runs the request/ready
// handshake to instruction memory and drives the IF/ID register inputs
// every cycle. The IF/ID register has no enable, so a stall is realised by
// re-presenting the instruction that ID already holds (mirrored locally).
module if_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] Instr,
   output logic [31:0] pc4,
   output logic        flush,
   output logic [31:0] fetch_pc
);

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  buf_instr_q, buf_instr_d;
   logic [31:0]  buf_pc4_q, buf_pc4_d;
   logic [31:0]  pend_pc_q, pend_pc_d;
   logic [31:0]  id_instr_q, id_instr_d;
   logic [31:0]  id_pc4_q, id_pc4_d;
   logic         id_valid_q, id_valid_d;

   logic [31:0]  pc_plus4;
   logic [31:0]  redir_tgt;
   logic         mem_hit;
   logic [31:0]  instr_o;
   logic [31:0]  pc4_o;
   logic         flush_o;

   assign pc_plus4  = fetch_pc_q + 32'd4;   // wraps modulo 2^32
   assign redir_tgt = word_align(redirect_pc);
   assign mem_hit   = (state_q == S_REQ) && imem_ready;

   // Memory request: no request while parked in S_HOLD or while in reset.
   assign imem_req  = !clr && ((state_q == S_REQ) || (state_q == S_DROP));
   assign imem_addr = fetch_pc_q;
   assign fetch_pc  = fetch_pc_q;

   assign Instr = instr_o;
   assign pc4   = pc4_o;
   assign flush = flush_o;

   // Output mux toward IF/ID in priority order; a bubble always carries zeros.
   always_comb begin
      instr_o = NOP_WORD;
      pc4_o   = 32'd0;
      flush_o = 1'b1;
      if (clr) begin
         flush_o = 1'b1;
      end else if (redirect) begin
         flush_o = 1'b1;
      end else if (stall) begin
         // Re-present ID's instruction; a bubble in ID stays a bubble.
         if (id_valid_q) begin
            instr_o = id_instr_q;
            pc4_o   = id_pc4_q;
            flush_o = 1'b0;
         end
      end else if (mem_hit) begin
         // Zero-cycle delivery straight from memory.
         instr_o = imem_rdata;
         pc4_o   = pc_plus4;
         flush_o = 1'b0;
      end else if (state_q == S_HOLD) begin
         instr_o = buf_instr_q;
         pc4_o   = buf_pc4_q;
         flush_o = 1'b0;
      end
   end

   // Fetch FSM next-state, fetch PC, hold buffer and pending-target update.
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      buf_instr_d = buf_instr_q;
      buf_pc4_d   = buf_pc4_q;
      pend_pc_d   = pend_pc_q;
      case (state_q)
         S_REQ: begin
            if (redirect) begin
               if (imem_ready) begin
                  // Returning word is wrong-path; restart at the target.
                  fetch_pc_d = redir_tgt;
               end else begin
                  // Request cannot be withdrawn; remember target, drain it.
                  pend_pc_d = redir_tgt;
                  state_d   = S_DROP;
               end
            end else if (imem_ready) begin
               fetch_pc_d = pc_plus4;
               if (stall) begin
                  buf_instr_d = imem_rdata;
                  buf_pc4_d   = pc_plus4;
                  state_d     = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (redirect) begin
               fetch_pc_d = redir_tgt;
               state_d    = S_REQ;
            end else if (!stall) begin
               state_d = S_REQ;
            end
         end
         S_DROP: begin
            if (redirect) begin
               pend_pc_d = redir_tgt;
            end
            if (imem_ready) begin
               fetch_pc_d = redirect ? redir_tgt : pend_pc_q;
               state_d    = S_REQ;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   // Mirror of what the IF/ID register captures at the coming edge.
   always_comb begin
      id_instr_d = instr_o;
      id_pc4_d   = pc4_o;
      id_valid_d = ~flush_o;
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= S_REQ;
         fetch_pc_q  <= RESET_PC;
         buf_instr_q <= 32'd0;
         buf_pc4_q   <= 32'd0;
         pend_pc_q   <= 32'd0;
         id_instr_q  <= 32'd0;
         id_pc4_q    <= 32'd0;
         id_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         buf_instr_q <= buf_instr_d;
         buf_pc4_q   <= buf_pc4_d;
         pend_pc_q   <= pend_pc_d;
         id_instr_q  <= id_instr_d;
         id_pc4_q    <= id_pc4_d;
         id_valid_q  <= id_valid_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the fetch behaviour.
module tb_if_fetch_unit;

   logic        clk;
   logic        clr;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] Instr;
   logic [31:0] pc4;
   logic        flush;
   logic [31:0] fetch_pc;

   int n_tests = 0;
   int n_fail  = 0;

   if_fetch_unit dut (
      .clk        (clk),
      .clr        (clr),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_ready (imem_ready),
      .Instr      (Instr),
      .pc4        (pc4),
      .flush      (flush),
      .fetch_pc   (fetch_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: next address to fetch, a queue of parked words,
   // a "discard the in-flight word" flag with its target, and ID contents.
   typedef struct {
      logic [31:0] ins;
      logic [31:0] p4;
   } ent_t;

   logic [31:0] m_pc;
   logic        m_disc;
   logic [31:0] m_tgt;
   ent_t        hq[$];
   logic [31:0] m_id_ins;
   logic [31:0] m_id_p4;
   logic        m_id_v;

   task automatic model_reset();
      m_pc     = 32'h0000_3000;
      m_disc   = 1'b0;
      m_tgt    = 32'd0;
      hq.delete();
      m_id_ins = 32'd0;
      m_id_p4  = 32'd0;
      m_id_v   = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs at the falling edge, check, then advance the model.
   task automatic step(input logic s, input logic r, input logic [31:0] rp, input logic rdy);
      logic [31:0] e_ins, e_p4, tgt;
      logic        e_fl, e_req;
      ent_t        e;
      @(negedge clk);
      stall       = s;
      redirect    = r;
      redirect_pc = rp;
      imem_ready  = rdy;
      imem_rdata  = rdy ? (m_pc ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
      #1;
      tgt   = rp & 32'hFFFF_FFFC;
      e_req = (hq.size() == 0);
      e_ins = 32'd0;
      e_p4  = 32'd0;
      e_fl  = 1'b1;
      if (r) begin
         e_fl = 1'b1;
      end else if (s) begin
         if (m_id_v) begin
            e_ins = m_id_ins;
            e_p4  = m_id_p4;
            e_fl  = 1'b0;
         end
      end else if (hq.size() != 0) begin
         e_ins = hq[0].ins;
         e_p4  = hq[0].p4;
         e_fl  = 1'b0;
      end else if (!m_disc && rdy) begin
         e_ins = m_pc ^ 32'hA5A5_0000;
         e_p4  = m_pc + 32'd4;
         e_fl  = 1'b0;
      end
      chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
      chk("imem_addr", imem_addr, m_pc);
      chk("fetch_pc", fetch_pc, m_pc);
      chk("Instr", Instr, e_ins);
      chk("pc4", pc4, e_p4);
      chk("flush", {31'd0, flush}, {31'd0, e_fl});
      @(posedge clk);
      if (hq.size() != 0) begin
         if (r) begin
            hq.delete();
            m_pc = tgt;
         end else if (!s) begin
            void'(hq.pop_front());
         end
      end else if (m_disc) begin
         if (r) m_tgt = tgt;
         if (rdy) begin
            m_pc   = m_tgt;
            m_disc = 1'b0;
         end
      end else if (r) begin
         if (rdy) m_pc = tgt;
         else begin
            m_disc = 1'b1;
            m_tgt  = tgt;
         end
      end else if (rdy) begin
         if (s) begin
            e.ins = m_pc ^ 32'hA5A5_0000;
            e.p4  = m_pc + 32'd4;
            hq.push_back(e);
         end
         m_pc = m_pc + 32'd4;
      end
      m_id_ins = e_ins;
      m_id_p4  = e_p4;
      m_id_v   = ~e_fl;
   endtask

   task automatic check_in_reset();
      chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd1);
      chk("rst_Instr", Instr, 32'd0);
      chk("rst_pc4", pc4, 32'd0);
      chk("rst_fetch_pc", fetch_pc, 32'h0000_3000);
   endtask

   initial begin
      clr         = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      imem_ready  = 1'b0;
      imem_rdata  = 32'd0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_in_reset();
      @(posedge clk);
      #2 clr = 1'b0;

      // Back-to-back single-cycle memory: 0x3000, 0x3004, 0x3008.
      repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1);

      // Memory answering every third cycle.
      repeat (3) begin
         step(1'b0, 1'b0, 32'd0, 1'b0);
         step(1'b0, 1'b0, 32'd0, 1'b0);
         step(1'b0, 1'b0, 32'd0, 1'b1);
      end

      // Stall with a word returning mid-stall, then release.
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 32'd0, 1'b1);
      step(1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b1);

      // Misaligned redirect while the memory is busy.
      step(1'b0, 1'b1, 32'h0000_3102, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b1);

      // Redirect together with stall.
      step(1'b1, 1'b1, 32'h0000_3200, 1'b1);
      step(1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b1);

      // PC wrap at the top of the address space.
      step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b1);

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0),
              $urandom(),
              ($urandom_range(0, 1) == 1));
      end

      // Clear asserted while a request is waiting.
      step(1'b0, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      stall      = 1'b0;
      redirect   = 1'b0;
      imem_ready = 1'b0;
      #1 clr = 1'b1;
      #1;
      check_in_reset();
      model_reset();
      @(posedge clk);
      #2 clr = 1'b0;
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
